// File: rtl/sm2201_isa_io_controller.sv
// rtl/sm2201_isa_io_controller.sv - ISA 8-bit I/O cycle decoder with wait states and byte-pair packing
module sm2201_isa_io_controller #(
  parameter logic [9:0] BASE_ADDR   = 10'h110,
  parameter int         WAIT_STATES = 2
) (
  input  logic        isa_clk,
  input  logic        isa_reset,
  input  logic [9:0]  isa_addr,
  input  logic        isa_aen,
  input  logic        isa_ior,
  input  logic        isa_iow,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_chrdy,
  output logic        reg_sel,
  output logic        reg_wr_stb,
  output logic [15:0] reg_wdata,
  output logic        reg_rd_stb,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_LATCH,
    ST_HOLD
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        ior_q;
  logic        iow_q;
  logic        ior_qd;
  logic        iow_qd;
  logic [3:0]  wait_cnt;
  logic [1:0]  offset;
  logic        dir_rd;
  logic [7:0]  wr_byte;
  logic [7:0]  hold_data;
  logic [7:0]  hold_cmd;
  logic [15:0] rd_latch;
  logic [7:0]  data_out_r;
  logic [15:0] wdata_r;

  logic        strobe_fall;
  logic        decode_hit;
  logic        cycle_start;
  logic        strobe_released;
  logic [7:0]  hold_lo;
  logic        wr_commit;

  // A start is a falling edge of either sampled strobe, in the window, not DMA, and not both strobes low.
  assign strobe_fall = (ior_qd & ~ior_q) | (iow_qd & ~iow_q);
  assign decode_hit  = ~isa_aen && (isa_addr[9:2] == BASE_ADDR[9:2]) && (ior_q | iow_q);
  assign cycle_start = strobe_fall & decode_hit;

  // Abort looks at the strobe being sampled at this edge, so a release in the last WAIT cycle still aborts.
  assign strobe_released = dir_rd ? isa_ior : isa_iow;

  assign hold_lo   = offset[1] ? hold_cmd : hold_data;
  assign wr_commit = (state == ST_ACCESS) && !dir_rd && offset[0];

  // Strobe synchronisers and FSM state register.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      ior_q  <= 1'b1;
      iow_q  <= 1'b1;
      ior_qd <= 1'b1;
      iow_qd <= 1'b1;
      state  <= ST_IDLE;
    end else begin
      ior_q  <= isa_ior;
      iow_q  <= isa_iow;
      ior_qd <= ior_q;
      iow_qd <= iow_q;
      state  <= state_nxt;
    end
  end

  // Next-state decode for the ISA cycle sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cycle_start) begin
          state_nxt = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (strobe_released) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (ior_q && iow_q) begin
          state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture the cycle parameters on start and count wait states.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      offset   <= 2'b00;
      dir_rd   <= 1'b0;
      wr_byte  <= 8'h00;
      wait_cnt <= 4'h0;
    end else begin
      if (state == ST_IDLE && cycle_start) begin
        offset <= isa_addr[1:0];
        dir_rd <= ~ior_q;
        if (ior_q) begin
          wr_byte <= isa_data_in;
        end
      end
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'h0;
      end
    end
  end

  // Write path: low bytes go to the per-register holding byte, high bytes commit the word.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      hold_data <= 8'h00;
      hold_cmd  <= 8'h00;
      wdata_r   <= 16'h0000;
    end else if (state == ST_ACCESS && !dir_rd) begin
      if (!offset[0]) begin
        if (offset[1]) begin
          hold_cmd <= wr_byte;
        end else begin
          hold_data <= wr_byte;
        end
      end else begin
        wdata_r <= {wr_byte, hold_lo};
      end
    end
  end

  // Read path: low-byte reads capture the whole word, high-byte reads return the latched upper half.
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      rd_latch   <= 16'h0000;
      data_out_r <= 8'h00;
    end else if (state == ST_LATCH && dir_rd) begin
      if (!offset[0]) begin
        rd_latch <= reg_rdata;
      end
      data_out_r <= offset[0] ? rd_latch[15:8] : reg_rdata[7:0];
    end
  end

  // The committed word is presented during the strobe cycle and held afterwards.
  assign reg_wdata    = wr_commit ? {wr_byte, hold_lo} : wdata_r;
  assign reg_wr_stb   = wr_commit;
  assign reg_rd_stb   = (state == ST_ACCESS) && dir_rd && !offset[0];
  assign reg_sel      = ((state == ST_ACCESS) || (state == ST_LATCH)) ? offset[1] : 1'b0;
  assign isa_chrdy    = !((state == ST_WAIT) || (state == ST_ACCESS) || (state == ST_LATCH));
  assign isa_data_oe  = (state == ST_HOLD) && dir_rd;
  assign isa_data_out = data_out_r;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_sm2201_isa_io_controller.sv
// tb/tb_sm2201_isa_io_controller.sv - table-driven bench for sm2201_isa_io_controller
module tb_sm2201_isa_io_controller;

  logic        isa_clk = 1'b0;
  logic        isa_reset;
  logic [9:0]  isa_addr;
  logic        isa_aen;
  logic        isa_ior;
  logic        isa_iow;
  logic [7:0]  isa_data_in;
  logic [7:0]  isa_data_out;
  logic        isa_data_oe;
  logic        isa_chrdy;
  logic        reg_sel;
  logic        reg_wr_stb;
  logic [15:0] reg_wdata;
  logic        reg_rd_stb;
  logic [15:0] reg_rdata;
  logic        busy;

  sm2201_isa_io_controller #(
    .BASE_ADDR  (10'h110),
    .WAIT_STATES(2)
  ) dut (
    .isa_clk     (isa_clk),
    .isa_reset   (isa_reset),
    .isa_addr    (isa_addr),
    .isa_aen     (isa_aen),
    .isa_ior     (isa_ior),
    .isa_iow     (isa_iow),
    .isa_data_in (isa_data_in),
    .isa_data_out(isa_data_out),
    .isa_data_oe (isa_data_oe),
    .isa_chrdy   (isa_chrdy),
    .reg_sel     (reg_sel),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wdata   (reg_wdata),
    .reg_rd_stb  (reg_rd_stb),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  always #60 isa_clk = ~isa_clk;

  typedef struct {
    bit          wr;
    bit          both;
    logic        aen;
    logic [9:0]  addr;
    logic [7:0]  din;
    logic [15:0] rdata;
    int          exp_low;
    int          exp_wr;
    int          exp_rd;
    logic        exp_sel;
    logic [15:0] exp_wdata;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[14];

  int errors = 0;
  int checks = 0;

  int          n_low;
  int          n_wr;
  int          n_rd;
  int          n_oe_bad;
  bit          seen_hold;
  logic        sel_at;
  logic [15:0] wd_at;
  logic [7:0]  dout_at;
  logic        oe_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    n_low = 0; n_wr = 0; n_rd = 0; n_oe_bad = 0; seen_hold = 0;
    sel_at = 1'b0; wd_at = 16'h0; dout_at = 8'h0; oe_at = 1'b0;
  endtask

  task automatic sample_cycle();
    @(negedge isa_clk);
    if (!isa_chrdy) n_low++;
    if (reg_wr_stb) begin
      n_wr++;
      sel_at = reg_sel;
      wd_at  = reg_wdata;
    end
    if (reg_rd_stb) begin
      n_rd++;
      sel_at = reg_sel;
    end
    if (busy && isa_chrdy) begin
      seen_hold = 1;
      dout_at   = isa_data_out;
      oe_at     = isa_data_oe;
    end else if (isa_data_oe) begin
      n_oe_bad++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    clear_obs();
    @(negedge isa_clk);
    isa_addr    = v.addr;
    isa_aen     = v.aen;
    isa_data_in = v.din;
    reg_rdata   = v.rdata;
    if (v.both) begin
      isa_ior = 1'b0;
      isa_iow = 1'b0;
    end else if (v.wr) begin
      isa_iow = 1'b0;
    end else begin
      isa_ior = 1'b0;
    end
    for (int c = 0; c < 12; c++) sample_cycle();
    isa_ior = 1'b1;
    isa_iow = 1'b1;
    isa_aen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample_cycle();
      if (!busy) break;
    end
    check($sformatf("v%0d chrdy_low_cycles", idx), n_low, v.exp_low);
    check($sformatf("v%0d wr_stb_count", idx), n_wr, v.exp_wr);
    check($sformatf("v%0d rd_stb_count", idx), n_rd, v.exp_rd);
    if (v.exp_wr != 0 || v.exp_rd != 0) check($sformatf("v%0d reg_sel", idx), sel_at, v.exp_sel);
    if (v.exp_wr != 0) check($sformatf("v%0d reg_wdata", idx), wd_at, v.exp_wdata);
    if (v.exp_low != 0 && !v.wr) begin
      check($sformatf("v%0d hold_seen", idx), seen_hold, 1);
      check($sformatf("v%0d data_out", idx), dout_at, v.exp_dout);
      check($sformatf("v%0d data_oe_in_hold", idx), oe_at, 1);
    end
    check($sformatf("v%0d data_oe_outside_hold", idx), n_oe_bad, 0);
    check($sformatf("v%0d back_to_idle", idx), busy, 0);
  endtask

  task automatic wait_busy(input string name);
    bit got;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      sample_cycle();
      if (busy) begin
        got = 1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  task automatic do_abort();
    clear_obs();
    @(negedge isa_clk);
    isa_addr    = 10'h113;
    isa_data_in = 8'h55;
    isa_iow     = 1'b0;
    wait_busy("abort enter_wait");
    sample_cycle();
    isa_iow = 1'b1;
    sample_cycle();
    check("abort busy_after_release", busy, 0);
    check("abort chrdy_after_release", isa_chrdy, 1);
    for (int c = 0; c < 6; c++) sample_cycle();
    check("abort wr_stb_count", n_wr, 0);
    check("abort chrdy_low_cycles", n_low, 2);
  endtask

  task automatic do_reset_mid();
    clear_obs();
    @(negedge isa_clk);
    isa_addr  = 10'h110;
    reg_rdata = 16'h5A5A;
    isa_ior   = 1'b0;
    wait_busy("rstmid enter_wait");
    isa_reset = 1'b0;
    #1;
    check("rstmid chrdy", isa_chrdy, 1);
    check("rstmid busy", busy, 0);
    check("rstmid rd_stb", reg_rd_stb, 0);
    check("rstmid data_out", isa_data_out, 0);
    check("rstmid reg_wdata", reg_wdata, 0);
    sample_cycle();
    sample_cycle();
    isa_ior = 1'b1;
    sample_cycle();
    isa_reset = 1'b1;
    sample_cycle();
    sample_cycle();
    check("rstmid rd_stb_count", n_rd, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr both aen addr     din    rdata     low wr rd sel wdata     dout
    vecs[0]  = '{1, 0, 0, 10'h110, 8'h08, 16'h0000, 4, 0, 0, 0, 16'h0000, 8'h00};
    vecs[1]  = '{1, 0, 0, 10'h111, 8'h42, 16'h0000, 4, 1, 0, 0, 16'h4208, 8'h00};
    vecs[2]  = '{0, 0, 0, 10'h110, 8'h00, 16'h4208, 4, 0, 1, 0, 16'h0000, 8'h08};
    vecs[3]  = '{0, 0, 0, 10'h111, 8'h00, 16'hFFFF, 4, 0, 0, 0, 16'h0000, 8'h42};
    vecs[4]  = '{0, 0, 1, 10'h113, 8'h00, 16'h1111, 0, 0, 0, 0, 16'h0000, 8'h00};
    vecs[5]  = '{1, 0, 0, 10'h114, 8'hEE, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00};
    vecs[6]  = '{0, 1, 0, 10'h110, 8'hEE, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00};
    vecs[7]  = '{1, 0, 0, 10'h112, 8'h3C, 16'h0000, 4, 0, 0, 0, 16'h0000, 8'h00};
    vecs[8]  = '{1, 0, 0, 10'h113, 8'h77, 16'h0000, 4, 1, 0, 1, 16'h773C, 8'h00};
    vecs[9]  = '{1, 0, 0, 10'h111, 8'h99, 16'h0000, 4, 1, 0, 0, 16'h9908, 8'h00};
    vecs[10] = '{0, 0, 0, 10'h112, 8'h00, 16'h1234, 4, 0, 1, 1, 16'h0000, 8'h34};
    vecs[11] = '{0, 0, 0, 10'h113, 8'h00, 16'h0000, 4, 0, 0, 0, 16'h0000, 8'h12};
    vecs[12] = '{0, 0, 0, 10'h110, 8'h00, 16'hBEEF, 4, 0, 1, 0, 16'h0000, 8'hEF};
    vecs[13] = '{1, 0, 0, 10'h111, 8'hAB, 16'h0000, 4, 1, 0, 0, 16'hAB00, 8'h00};

    isa_reset   = 1'b0;
    isa_addr    = 10'h000;
    isa_aen     = 1'b0;
    isa_ior     = 1'b1;
    isa_iow     = 1'b1;
    isa_data_in = 8'h00;
    reg_rdata   = 16'h0000;
    repeat (3) @(negedge isa_clk);
    check("reset chrdy", isa_chrdy, 1);
    check("reset data_oe", isa_data_oe, 0);
    check("reset wr_stb", reg_wr_stb, 0);
    check("reset rd_stb", reg_rd_stb, 0);
    check("reset busy", busy, 0);
    check("reset reg_wdata", reg_wdata, 16'h0000);
    check("reset data_out", isa_data_out, 8'h00);
    isa_reset = 1'b1;
    repeat (2) @(negedge isa_clk);

    for (int i = 0; i < 14; i++) begin
      if (i == 8) do_abort();
      if (i == 12) do_reset_mid();
      run_vec(i, vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
